// File: rtl/multi_clk_divider.sv
// multi_clk_divider: CHANNELS divided clocks with ticks and per-channel divisors; CLKDIV_SYNC_EN adds a sync input.
// Latency: out_clk/tick/n_clks registered (1 cycle); wr_ready combinational.
// Backpressure: wr_ready drops while the addressed channel holds an unapplied divisor.
module multi_clk_divider #(
   parameter int CHANNELS    = 4,
   parameter int CNT_WIDTH   = 16,
   parameter int DEFAULT_DIV = 2,
   localparam int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                          in_clk,
   input  logic                          reset,
   input  logic                          enable,
`ifdef CLKDIV_SYNC_EN
   input  logic                          sync,
`endif
   input  logic                          wr_en,
   input  logic [CHW-1:0]                wr_chan,
   input  logic [CNT_WIDTH-1:0]          wr_div,
   output logic                          wr_ready,
   output logic [CHANNELS-1:0]           out_clk,
   output logic [CHANNELS-1:0]           tick,
   output logic [CHANNELS*CNT_WIDTH-1:0] n_clks
);

   typedef logic [CNT_WIDTH-1:0] cnt_t;

   typedef struct packed {
      cnt_t cnt;
      cnt_t div;
      cnt_t pend_div;
      logic pend;
   } chan_t;

   localparam cnt_t DIV_RST = cnt_t'(DEFAULT_DIV);
   localparam cnt_t DIV_MIN = cnt_t'(2);
   localparam cnt_t ONE     = cnt_t'(1);

   chan_t               st_q [CHANNELS];
   chan_t               st_d [CHANNELS];
   cnt_t                half [CHANNELS];
   logic [CHANNELS-1:0] restart;
   logic [CHANNELS-1:0] out_d;
   logic [CHANNELS-1:0] tick_d;
   logic                sync_hit;

`ifdef CLKDIV_SYNC_EN
   assign sync_hit = enable & sync;
`else
   assign sync_hit = 1'b0;
`endif

   // Out-of-range channels never match, so those writes see ready=1 and vanish.
   always_comb begin
      wr_ready = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
         if (wr_chan == CHW'(i)) wr_ready = !st_q[i].pend;
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         st_d[i]    = st_q[i];
         out_d[i]   = out_clk[i];
         tick_d[i]  = 1'b0;
         half[i]    = '0;
         restart[i] = enable & ((st_q[i].cnt == st_q[i].div - ONE) | sync_hit);

         // A pending divisor takes effect exactly at a period boundary.
         if (restart[i] && st_q[i].pend) begin
            st_d[i].div  = st_q[i].pend_div;
            st_d[i].pend = 1'b0;
         end

         if (enable) begin
            st_d[i].cnt = restart[i] ? '0 : st_q[i].cnt + ONE;
            half[i]     = st_d[i].div - (st_d[i].div >> 1);
            out_d[i]    = st_d[i].cnt < half[i];
            tick_d[i]   = st_d[i].cnt == '0;
         end

         if (wr_en && (wr_chan == CHW'(i)) && !st_q[i].pend) begin
            st_d[i].pend_div = (wr_div < DIV_MIN) ? DIV_MIN : wr_div;
            st_d[i].pend     = 1'b1;
         end
      end
   end

   always_ff @(posedge in_clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            st_q[i] <= '{cnt: '0, div: DIV_RST, pend_div: DIV_RST, pend: 1'b0};
         end
         out_clk <= '0;
         tick    <= '0;
      end else begin
         st_q    <= st_d;
         out_clk <= out_d;
         tick    <= tick_d;
      end
   end

   always_comb begin
      n_clks = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         n_clks[i*CNT_WIDTH +: CNT_WIDTH] = st_q[i].cnt;
      end
   end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Bench for multi_clk_divider: phase-based reference model checked every cycle plus directed scenarios.
module tb_multi_clk_divider;
   localparam int CH  = 4;
   localparam int CW  = 16;
   localparam int DEF = 2;

   logic             in_clk = 1'b0;
   logic             reset;
   logic             enable;
   logic             wr_en;
   logic [1:0]       wr_chan;
   logic [CW-1:0]    wr_div;
   logic             wr_ready;
   logic [CH-1:0]    out_clk;
   logic [CH-1:0]    tick;
   logic [CH*CW-1:0] n_clks;
`ifdef CLKDIV_SYNC_EN
   logic             sync = 1'b0;
`endif

   multi_clk_divider #(.CHANNELS(CH), .CNT_WIDTH(CW), .DEFAULT_DIV(DEF)) dut (
      .in_clk  (in_clk),
      .reset   (reset),
      .enable  (enable),
`ifdef CLKDIV_SYNC_EN
      .sync    (sync),
`endif
      .wr_en   (wr_en),
      .wr_chan (wr_chan),
      .wr_div  (wr_div),
      .wr_ready(wr_ready),
      .out_clk (out_clk),
      .tick    (tick),
      .n_clks  (n_clks)
   );

   always #5 in_clk = ~in_clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference: each channel is a phase within its current period plus one optional queued divisor.
   int            ph  [CH];
   int            dm  [CH];
   int            pdm [CH];
   bit            pf  [CH];
   logic [CH-1:0] out_m  = '0;
   logic [CH-1:0] tick_m = '0;
   bit            mvalid = 1'b0;

   task automatic model_step();
      if (reset) begin
         for (int c = 0; c < CH; c++) begin
            ph[c] = 0; dm[c] = DEF; pdm[c] = DEF; pf[c] = 1'b0;
         end
         out_m  = '0;
         tick_m = '0;
         mvalid = 1'b1;
      end else begin
         for (int c = 0; c < CH; c++) begin
            bit acc;
            acc = wr_en && (int'(wr_chan) == c) && !pf[c];
            if (enable) begin
               ph[c]++;
               if (ph[c] == dm[c]) begin
                  ph[c] = 0;
                  if (pf[c]) begin dm[c] = pdm[c]; pf[c] = 1'b0; end
               end
               tick_m[c] = (ph[c] == 0);
               out_m[c]  = (ph[c] < (dm[c] + 1) / 2);
            end else begin
               tick_m[c] = 1'b0;
            end
            if (acc) begin
               pdm[c] = (wr_div < 2) ? 2 : int'(wr_div);
               pf[c]  = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [63:0] n_exp();
      logic [63:0] v = '0;
      for (int c = 0; c < CH; c++) v[c*CW +: CW] = CW'(ph[c]);
      return v;
   endfunction

   initial forever begin
      @(posedge in_clk);
      model_step();
   end

   // Per-cycle comparison and tick-interval recording for one watched channel.
   int cyc = 0;
   int last_t [CH] = '{default: 0};
   int watch = 0;
   int iv_q [$];

   initial forever begin
      @(negedge in_clk);
      cyc++;
      if (mvalid) begin
         chk("out_clk", 64'(out_clk), 64'(out_m));
         chk("tick", 64'(tick), 64'(tick_m));
         chk("n_clks", 64'(n_clks), n_exp());
         chk("wr_ready", 64'(wr_ready), 64'(!pf[wr_chan]));
      end
      for (int c = 0; c < CH; c++) begin
         if (tick[c] === 1'b1) begin
            if (c == watch) iv_q.push_back(cyc - last_t[c]);
            last_t[c] = cyc;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge in_clk);
      #1;
   endtask

   task automatic do_write(input int ch, input int dv, output int stalls);
      wr_en   = 1'b1;
      wr_chan = 2'(ch);
      wr_div  = CW'(dv);
      stalls  = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge in_clk);
         if (wr_ready === 1'b1) break;
         stalls++;
      end
      if (stalls >= 60) begin
         total++; bad++;
         $display("FAIL write_timeout: ch=%0d got ready=0 want ready=1", ch);
      end
      @(posedge in_clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic check_switch(input string nm, input int old_d, input int d1, input int d2);
      int idx = -1;
      for (int k = 0; k < iv_q.size(); k++) begin
         if (iv_q[k] != old_d) begin idx = k; break; end
      end
      if (idx < 0 || idx + 1 >= iv_q.size()) begin
         total++; bad++;
         $display("FAIL %s: got %0d intervals without change want change to %0d", nm, iv_q.size(), d1);
      end else begin
         chk({nm, "_period1"}, 64'(iv_q[idx]), 64'(d1));
         chk({nm, "_period2"}, 64'(iv_q[idx+1]), 64'(d2));
      end
   endtask

   task automatic check_steady(input string nm, input int d);
      if (iv_q.size() < 3) begin
         total++; bad++;
         $display("FAIL %s: got %0d intervals want at least 3", nm, iv_q.size());
      end else begin
         chk({nm, "_iv1"}, 64'(iv_q[1]), 64'(d));
         chk({nm, "_iv2"}, 64'(iv_q[2]), 64'(d));
      end
   endtask

   initial begin
      int st;
      reset = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_chan = '0; wr_div = '0;
      repeat (3) @(posedge in_clk);
      @(negedge in_clk);
      chk("rst_out", 64'(out_clk), 64'h0);
      chk("rst_tick", 64'(tick), 64'h0);
      chk("rst_n", 64'(n_clks), 64'h0);
      chk("rst_ready", 64'(wr_ready), 64'h1);
      @(posedge in_clk); #1;
      reset = 1'b0;

      // Default D=2: first edge counts to 1, second edge rises with tick.
      @(posedge in_clk);
      @(negedge in_clk);
      chk("edge1_out", 64'(out_clk), 64'h0);
      chk("edge1_n", 64'(n_clks), 64'h0001_0001_0001_0001);
      @(negedge in_clk);
      chk("edge2_out", 64'(out_clk), 64'hF);
      chk("edge2_tick", 64'(tick), 64'hF);
      chk("edge2_n", 64'(n_clks), 64'h0);
      step(3);

      watch = 1; iv_q.delete();
      do_write(1, 5, st);
      @(negedge in_clk);
      chk("ch1_pending", 64'(wr_ready), 64'h0);
      step(20);
      check_switch("ch1", 2, 5, 5);

      do_write(2, 0, st);
      enable = 1'b0;
      step(20);
      @(negedge in_clk);
      chk("ch2_frozen_ready", 64'(wr_ready), 64'h0);
      chk("frozen_tick", 64'(tick), 64'h0);
      @(posedge in_clk); #1;
      enable = 1'b1;
      watch = 2; iv_q.delete();
      step(10);
      check_steady("ch2_clamped", 2);

      watch = 3; iv_q.delete();
      do_write(3, 7, st);
      do_write(3, 4, st);
      chk("ch3_stalled", 64'(st > 0), 64'h1);
      step(20);
      check_switch("ch3", 2, 7, 4);

      do_write(0, 7, st);
      step(10);
      do_write(2, 5, st);
      reset = 1'b1;
      @(posedge in_clk);
      @(negedge in_clk);
      chk("midrst_out", 64'(out_clk), 64'h0);
      chk("midrst_tick", 64'(tick), 64'h0);
      chk("midrst_n", 64'(n_clks), 64'h0);
      chk("midrst_ready", 64'(wr_ready), 64'h1);
      @(posedge in_clk); #1;
      reset = 1'b0;
      watch = 1; iv_q.delete();
      step(12);
      check_steady("ch1_after_rst", DEF);

      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
